// File: rtl/cdb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_pkg
//   Shared constants for the common-data-bus arbiter: default tag/data
//   widths, default per-source FIFO depth and the result-source encoding
//   that is also driven out on cdb_src.
// ---------------------------------------------------------------------------
package cdb_arbiter_pkg;

    localparam int ROB_ID_W_DEF       = 5;
    localparam int DATA_W_DEF         = 32;
    localparam int FIFO_DEPTH_BIT_DEF = 1;

    // Source encoding; LSB is the reset value of last_grant so ALU wins the
    // first tie after reset or flush.
    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// ---------------------------------------------------------------------------
// cdb_arbiter_if
//   Producer and broadcast signals of the CDB arbiter.
//   master : result producers / consumers side (drives *_valid, *_rob_id,
//            *_val; observes *_ready and the cdb_* broadcast)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
);
    logic                alu_valid;
    logic [ROB_ID_W-1:0] alu_rob_id;
    logic [DATA_W-1:0]   alu_val;
    logic                alu_ready;

    logic                lsb_valid;
    logic [ROB_ID_W-1:0] lsb_rob_id;
    logic [DATA_W-1:0]   lsb_val;
    logic                lsb_ready;

    logic                cdb_valid;
    logic [ROB_ID_W-1:0] cdb_rob_id;
    logic [DATA_W-1:0]   cdb_val;
    logic                cdb_src;

    modport master (
        output alu_valid, alu_rob_id, alu_val,
        output lsb_valid, lsb_rob_id, lsb_val,
        input  alu_ready, lsb_ready,
        input  cdb_valid, cdb_rob_id, cdb_val, cdb_src
    );

    modport slave (
        input  alu_valid, alu_rob_id, alu_val,
        input  lsb_valid, lsb_rob_id, lsb_val,
        output alu_ready, lsb_ready,
        output cdb_valid, cdb_rob_id, cdb_val, cdb_src
    );
endinterface

// File: rtl/cdb_src_fifo.sv
// ---------------------------------------------------------------------------
// cdb_src_fifo
//   Small per-source result FIFO (2**DEPTH_BIT entries of W bits).
//   clk_i / rst_ni : clock, async active-low reset
//   en_i           : global ready; low freezes pointers and count
//   flush_i        : synchronous empty, wins over en_i
//   push_i / din_i : write request (ignored when full)
//   pop_i          : read request (ignored when empty)
//   dout_o         : head entry
//   empty_o/full_o : status from current count only
// ---------------------------------------------------------------------------
module cdb_src_fifo #(
    parameter int DEPTH_BIT = 1,
    parameter int W         = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int                   DEPTH    = 1 << DEPTH_BIT;
    localparam logic [DEPTH_BIT:0]   FULL_CNT = (DEPTH_BIT+1)'(DEPTH);
    localparam logic [DEPTH_BIT:0]   CNT_ONE  = (DEPTH_BIT+1)'(1);
    localparam logic [DEPTH_BIT-1:0] PTR_ONE  = DEPTH_BIT'(1);

    logic [W-1:0]         mem_q [DEPTH];
    logic [DEPTH_BIT-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_BIT:0]   cnt_q;
    logic                 do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign dout_o  = mem_q[rd_ptr_q];

    // Full refuses a push even when the head pops on the same edge.
    assign do_push = en_i && !flush_i && push_i && !full_o;
    assign do_pop  = en_i && !flush_i && pop_i  && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (en_i) begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the count.
    always_ff @(posedge clk_i) begin
        if (do_push && rst_ni) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//   Shares the single result broadcast bus between the ALU and LSB result
//   producers. Each source is buffered in a cdb_src_fifo; one head per cycle
//   is granted round-robin and registered onto the cdb_* broadcast.
//   clk_in     : clock
//   rst_in     : async active-low reset
//   rdy_in     : global ready; low holds all state and outputs
//   clear_flag : synchronous flush (mispredict), same effect as reset
//   bus        : producer handshakes and cdb broadcast (slave modport)
// ---------------------------------------------------------------------------
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_ID_W       = ROB_ID_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int FIFO_DEPTH_BIT = FIFO_DEPTH_BIT_DEF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          clear_flag,
    cdb_arbiter_if.slave  bus
);
    localparam int EW = ROB_ID_W + DATA_W;

    logic [EW-1:0]       alu_head, lsb_head, gnt_head;
    logic                alu_empty, alu_full, lsb_empty, lsb_full;
    logic                alu_pop, lsb_pop;
    logic                gnt_vld;
    cdb_src_e            gnt_src;

    logic                cdb_valid_q, cdb_valid_d;
    logic [ROB_ID_W-1:0] cdb_rob_q, cdb_rob_d;
    logic [DATA_W-1:0]   cdb_val_q, cdb_val_d;
    cdb_src_e            cdb_src_q, cdb_src_d;
    cdb_src_e            last_q, last_d;

    cdb_src_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT), .W(EW)) u_alu_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .en_i    (rdy_in),
        .flush_i (clear_flag),
        .push_i  (bus.alu_valid),
        .pop_i   (alu_pop),
        .din_i   ({bus.alu_rob_id, bus.alu_val}),
        .dout_o  (alu_head),
        .empty_o (alu_empty),
        .full_o  (alu_full)
    );

    cdb_src_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT), .W(EW)) u_lsb_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .en_i    (rdy_in),
        .flush_i (clear_flag),
        .push_i  (bus.lsb_valid),
        .pop_i   (lsb_pop),
        .din_i   ({bus.lsb_rob_id, bus.lsb_val}),
        .dout_o  (lsb_head),
        .empty_o (lsb_empty),
        .full_o  (lsb_full)
    );

    assign bus.alu_ready = !alu_full;
    assign bus.lsb_ready = !lsb_full;

    // Round-robin on FIFO heads: on contention the source that did not win
    // last time goes; otherwise whichever is non-empty.
    always_comb begin
        gnt_vld = !alu_empty || !lsb_empty;
        gnt_src = CDB_SRC_ALU;
        if (!alu_empty && !lsb_empty)
            gnt_src = (last_q == CDB_SRC_ALU) ? CDB_SRC_LSB : CDB_SRC_ALU;
        else if (!lsb_empty)
            gnt_src = CDB_SRC_LSB;
    end

    assign alu_pop  = gnt_vld && (gnt_src == CDB_SRC_ALU);
    assign lsb_pop  = gnt_vld && (gnt_src == CDB_SRC_LSB);
    assign gnt_head = (gnt_src == CDB_SRC_LSB) ? lsb_head : alu_head;

    // Idle cycles broadcast all-zero so consumers never latch a stale tag.
    always_comb begin
        cdb_valid_d = gnt_vld;
        cdb_rob_d   = '0;
        cdb_val_d   = '0;
        cdb_src_d   = CDB_SRC_ALU;
        last_d      = last_q;
        if (gnt_vld) begin
            {cdb_rob_d, cdb_val_d} = gnt_head;
            cdb_src_d              = gnt_src;
            last_d                 = gnt_src;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= CDB_SRC_ALU;
            last_q      <= CDB_SRC_LSB;
        end else if (clear_flag) begin
            cdb_valid_q <= 1'b0;
            cdb_rob_q   <= '0;
            cdb_val_q   <= '0;
            cdb_src_q   <= CDB_SRC_ALU;
            last_q      <= CDB_SRC_LSB;
        end else if (rdy_in) begin
            cdb_valid_q <= cdb_valid_d;
            cdb_rob_q   <= cdb_rob_d;
            cdb_val_q   <= cdb_val_d;
            cdb_src_q   <= cdb_src_d;
            last_q      <= last_d;
        end
    end

    assign bus.cdb_valid  = cdb_valid_q;
    assign bus.cdb_rob_id = cdb_rob_q;
    assign bus.cdb_val    = cdb_val_q;
    assign bus.cdb_src    = cdb_src_q;

endmodule
